// File: rtl/pe_tile_scheduler.sv
// Loop-nest sequencer for the PE convolution array: walks row -> column tile
// -> input channel -> kernel tap over one OFM and hands each finished tile
// to the downstream accumulator/writeback buffer.
module pe_tile_scheduler #(
   parameter int NUM_PE = 16,
   parameter int KERNEL = 3,
   parameter int CNT_W  = 9,
   parameter int TAP_W  = $clog2(KERNEL*KERNEL)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [CNT_W-1:0]  cfg_ofm_w,
   input  logic [CNT_W-1:0]  cfg_ofm_h,
   input  logic [CNT_W-1:0]  cfg_channels,
   input  logic              stall,
   input  logic              tile_ack,
   output logic              en,
   output logic [NUM_PE-1:0] valid,
   output logic              change_channel,
   output logic              change_row,
   output logic              end_ofm,
   output logic              tile_done,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  cur_row,
   output logic [CNT_W-1:0]  cur_col,
   output logic [CNT_W-1:0]  cur_ch,
   output logic [TAP_W-1:0]  cur_tap
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

   localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(KERNEL*KERNEL - 1);
   localparam logic [CNT_W:0]   PE_STEP  = (CNT_W+1)'(NUM_PE);

   state_t state, state_nxt;

   logic [CNT_W-1:0]  ofm_w, ofm_h, channels;
   logic [CNT_W-1:0]  ofm_w_nxt, ofm_h_nxt, channels_nxt;
   logic [CNT_W-1:0]  row_nxt, col_nxt, ch_nxt;
   logic [TAP_W-1:0]  tap_nxt;
   logic              en_nxt, cc_nxt, cr_nxt, eo_nxt, td_nxt, busy_nxt, done_nxt;
   logic [NUM_PE-1:0] valid_nxt;

   // One extra bit so the next column base never wraps near the counter limit.
   logic [CNT_W:0]    col_step;
   logic [CNT_W-1:0]  ch_last, row_last;

   assign col_step = {1'b0, cur_col} + PE_STEP;
   assign ch_last  = channels - CNT_W'(1);
   assign row_last = ofm_h - CNT_W'(1);

   // Valid mask for a tile whose column base is col: the first min(NUM_PE, w-col) PEs.
   function automatic logic [NUM_PE-1:0] tile_mask(input logic [CNT_W-1:0] w,
                                                   input logic [CNT_W-1:0] col);
      logic [CNT_W-1:0]  rem;
      logic [NUM_PE-1:0] mask;
      rem  = w - col;
      mask = '0;
      for (int i = 0; i < NUM_PE; i++) begin
         if ($unsigned(i) < 32'(rem)) mask[i] = 1'b1;
      end
      return mask;
   endfunction

   // Next-state and next-output logic; every registered output is computed here.
   always_comb begin
      state_nxt    = state;
      ofm_w_nxt    = ofm_w;
      ofm_h_nxt    = ofm_h;
      channels_nxt = channels;
      row_nxt      = cur_row;
      col_nxt      = cur_col;
      ch_nxt       = cur_ch;
      tap_nxt      = cur_tap;
      en_nxt       = 1'b0;
      valid_nxt    = valid;
      cc_nxt       = 1'b0;
      cr_nxt       = 1'b0;
      eo_nxt       = 1'b0;
      td_nxt       = 1'b0;
      done_nxt     = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               ofm_w_nxt    = cfg_ofm_w;
               ofm_h_nxt    = cfg_ofm_h;
               channels_nxt = cfg_channels;
               row_nxt      = '0;
               col_nxt      = '0;
               ch_nxt       = '0;
               tap_nxt      = '0;
               if (cfg_ofm_w == '0 || cfg_ofm_h == '0 || cfg_channels == '0) begin
                  state_nxt = FIN;
                  done_nxt  = 1'b1;
               end else begin
                  state_nxt = RUN;
                  en_nxt    = !stall;
                  valid_nxt = tile_mask(cfg_ofm_w, '0);
               end
            end
         end
         RUN: begin
            if (en) begin
               if (cur_tap != TAP_LAST) begin
                  tap_nxt = cur_tap + TAP_W'(1);
               end else if (cur_ch != ch_last) begin
                  tap_nxt = '0;
                  ch_nxt  = cur_ch + CNT_W'(1);
               end else begin
                  state_nxt = DRAIN;
                  td_nxt    = 1'b1;
               end
            end
            if (state_nxt == RUN) en_nxt = !stall;
         end
         DRAIN: begin
            td_nxt = 1'b1;
            if (tile_ack) begin
               td_nxt  = 1'b0;
               ch_nxt  = '0;
               tap_nxt = '0;
               if (col_step < {1'b0, ofm_w}) begin
                  col_nxt   = col_step[CNT_W-1:0];
                  state_nxt = RUN;
                  en_nxt    = !stall;
                  valid_nxt = tile_mask(ofm_w, col_step[CNT_W-1:0]);
               end else if (cur_row != row_last) begin
                  row_nxt   = cur_row + CNT_W'(1);
                  col_nxt   = '0;
                  cr_nxt    = 1'b1;
                  state_nxt = RUN;
                  en_nxt    = !stall;
                  valid_nxt = tile_mask(ofm_w, '0);
               end else begin
                  state_nxt = FIN;
                  eo_nxt    = 1'b1;
                  done_nxt  = 1'b1;
                  valid_nxt = '0;
               end
            end
         end
         FIN: begin
            state_nxt = IDLE;
            valid_nxt = '0;
         end
         default: state_nxt = IDLE;
      endcase
      // The channel strobe rides on the enabled cycle that carries the last tap.
      cc_nxt   = en_nxt && (tap_nxt == TAP_LAST) && (ch_nxt != channels_nxt - CNT_W'(1));
      busy_nxt = (state_nxt != IDLE);
   end

   // State, configuration, counters and all outputs are registered here.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         ofm_w          <= '0;
         ofm_h          <= '0;
         channels       <= '0;
         cur_row        <= '0;
         cur_col        <= '0;
         cur_ch         <= '0;
         cur_tap        <= '0;
         en             <= 1'b0;
         valid          <= '0;
         change_channel <= 1'b0;
         change_row     <= 1'b0;
         end_ofm        <= 1'b0;
         tile_done      <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
      end else begin
         state          <= state_nxt;
         ofm_w          <= ofm_w_nxt;
         ofm_h          <= ofm_h_nxt;
         channels       <= channels_nxt;
         cur_row        <= row_nxt;
         cur_col        <= col_nxt;
         cur_ch         <= ch_nxt;
         cur_tap        <= tap_nxt;
         en             <= en_nxt;
         valid          <= valid_nxt;
         change_channel <= cc_nxt;
         change_row     <= cr_nxt;
         end_ofm        <= eo_nxt;
         tile_done      <= td_nxt;
         busy           <= busy_nxt;
         done           <= done_nxt;
      end
   end

endmodule

// File: tb/tb_pe_tile_scheduler.sv
// Self-checking bench for pe_tile_scheduler: table of full passes plus
// hand-written stall, backpressure, ignored-start and mid-pass reset cases.
module tb_pe_tile_scheduler;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start, stall, tile_ack;
   logic [8:0]  cfg_ofm_w, cfg_ofm_h, cfg_channels;
   logic        en, change_channel, change_row, end_ofm, tile_done, busy, done;
   logic [15:0] valid;
   logic [8:0]  cur_row, cur_col, cur_ch;
   logic [3:0]  cur_tap;

   pe_tile_scheduler dut (
      .clk(clk), .reset_n(reset_n), .start(start),
      .cfg_ofm_w(cfg_ofm_w), .cfg_ofm_h(cfg_ofm_h), .cfg_channels(cfg_channels),
      .stall(stall), .tile_ack(tile_ack),
      .en(en), .valid(valid), .change_channel(change_channel), .change_row(change_row),
      .end_ofm(end_ofm), .tile_done(tile_done), .busy(busy), .done(done),
      .cur_row(cur_row), .cur_col(cur_col), .cur_ch(cur_ch), .cur_tap(cur_tap)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Per-pass statistics collected by apply_stimulus.
   int en_cnt, cc_cnt, cr_cnt, eo_cnt, done_cnt, busy_cnt, tiles, last_cr_tiles;
   int stall_cycles, stall_at_tap, cc_after_stall, drain_en, frozen_err, ack_start_err;
   int post_busy, post_en, post_valid;
   logic [15:0] tile_valid [64];
   int          drain_len  [64];

   typedef struct {
      int          w, h, c, ack;
      int          exp_en, exp_cc, exp_cr, exp_cr_tiles, exp_tiles, exp_busy;
      logic [15:0] exp_v_first, exp_v_last;
   } vec_t;

   vec_t vecs [6];

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Runs one pass: pulses start, acks each tile after ack_delay tile_done cycles,
   // optionally stalls before stall_tap, re-pulses start mid-run, or resets mid-run.
   task automatic apply_stimulus(input int w, input int h, input int c, input int ack_delay,
                                 input int stall_tap, input bit restart_mid, input bit reset_mid);
      int cyc, k, stall_left, frz_tap, frz_ch;
      bit finished, aborted, prev_td, stall_done, after_stall;
      en_cnt = 0; cc_cnt = 0; cr_cnt = 0; eo_cnt = 0; done_cnt = 0; busy_cnt = 0;
      tiles = 0; last_cr_tiles = 0; stall_cycles = 0; stall_at_tap = 0;
      cc_after_stall = 0; drain_en = 0; frozen_err = 0; ack_start_err = 0;
      for (int i = 0; i < 64; i++) begin
         tile_valid[i] = '0;
         drain_len[i]  = 0;
      end
      cyc = 0; k = 0; stall_left = 0; frz_tap = 0; frz_ch = 0;
      finished = 0; aborted = 0; prev_td = 0; stall_done = 0; after_stall = 0;
      @(negedge clk);
      cfg_ofm_w = 9'(w); cfg_ofm_h = 9'(h); cfg_channels = 9'(c);
      start = 1'b1;
      while (!finished && !aborted && cyc < 4000) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) start = 1'b0;
         en_cnt   += int'(en);
         cc_cnt   += int'(change_channel);
         cr_cnt   += int'(change_row);
         eo_cnt   += int'(end_ofm);
         done_cnt += int'(done);
         if (busy) busy_cnt++;
         if (change_row) last_cr_tiles = tiles;
         if (busy && !en && !tile_done && !done) begin
            stall_cycles++;
            if (int'(cur_tap) == stall_tap) stall_at_tap++;
            after_stall = 1;
         end else if (en && after_stall) begin
            after_stall = 0;
            if (change_channel) cc_after_stall++;
         end
         if (tile_done) begin
            if (!prev_td) begin
               tile_valid[tiles] = valid;
               frz_tap = int'(cur_tap);
               frz_ch  = int'(cur_ch);
               tiles++;
               k = 0;
            end
            k++;
            drain_len[tiles-1]++;
            if (en) drain_en++;
            if (int'(cur_tap) != frz_tap || int'(cur_ch) != frz_ch) frozen_err++;
         end else if (prev_td && !done && !en) begin
            ack_start_err++;
         end
         prev_td = tile_done;
         if (done) finished = 1;
         tile_ack = tile_done && (k >= ack_delay);
         if (stall_tap >= 0 && !stall_done && en && tiles == 0 && cur_ch == 0 &&
             int'(cur_tap) == stall_tap - 1) begin
            stall = 1'b1;
            stall_left = 3;
            stall_done = 1;
         end else if (stall_left > 0) begin
            stall_left--;
            if (stall_left == 0) stall = 1'b0;
         end
         if (restart_mid && cyc == 5) begin
            start = 1'b1;
            cfg_ofm_w = 9'd1; cfg_ofm_h = 9'd1; cfg_channels = 9'd1;
         end
         if (restart_mid && cyc == 6) start = 1'b0;
         if (reset_mid && tiles == 1 && !tile_done && en && cur_tap == 4'd3) begin
            reset_n = 1'b0;
            #1;
            check_output("reset_en", 32'(en), 0);
            check_output("reset_busy", 32'(busy), 0);
            check_output("reset_valid", 32'(valid), 0);
            check_output("reset_col", 32'(cur_col), 0);
            check_output("reset_tap", 32'(cur_tap), 0);
            check_output("reset_cc", 32'(change_channel), 0);
            aborted = 1;
         end
      end
      if (aborted) begin
         @(negedge clk);
         reset_n = 1'b1;
      end else begin
         check_output("pass_completed", 32'(finished), 1);
      end
      tile_ack = 1'b0;
      stall = 1'b0;
      @(negedge clk);
      post_busy  = int'(busy);
      post_en    = int'(en);
      post_valid = int'(valid);
   endtask

   initial begin
      reset_n = 1'b0; start = 1'b0; stall = 1'b0; tile_ack = 1'b0;
      cfg_ofm_w = '0; cfg_ofm_h = '0; cfg_channels = '0;

      vecs[0] = '{20,  2, 2, 2,  72, 4, 1, 2,  4,  81, 16'hFFFF, 16'h000F};
      vecs[1] = '{16,  1, 1, 2,   9, 0, 0, 0,  1,  12, 16'hFFFF, 16'hFFFF};
      vecs[2] = '{4,   1, 2, 2,  18, 1, 0, 0,  1,  21, 16'h000F, 16'h000F};
      vecs[3] = '{33,  3, 1, 2,  81, 0, 2, 6,  9, 100, 16'hFFFF, 16'h0001};
      vecs[4] = '{511, 1, 1, 2, 288, 0, 0, 0, 32, 353, 16'hFFFF, 16'h7FFF};
      vecs[5] = '{8,   2, 0, 2,   0, 0, 0, 0,  0,   1, 16'h0000, 16'h0000};

      repeat (2) @(negedge clk);
      check_output("rst_en", 32'(en), 0);
      check_output("rst_busy", 32'(busy), 0);
      check_output("rst_done", 32'(done), 0);
      check_output("rst_valid", 32'(valid), 0);
      check_output("rst_row", 32'(cur_row), 0);
      check_output("rst_tile_done", 32'(tile_done), 0);
      reset_n = 1'b1;

      for (int i = 0; i < 6; i++) begin
         apply_stimulus(vecs[i].w, vecs[i].h, vecs[i].c, vecs[i].ack, -1, 0, 0);
         $display("[TB] vector %0d: w=%0d h=%0d ch=%0d", i, vecs[i].w, vecs[i].h, vecs[i].c);
         check_output("vec_en_count", en_cnt, vecs[i].exp_en);
         check_output("vec_cc_count", cc_cnt, vecs[i].exp_cc);
         check_output("vec_cr_count", cr_cnt, vecs[i].exp_cr);
         check_output("vec_cr_after_tile", last_cr_tiles, vecs[i].exp_cr_tiles);
         check_output("vec_tiles", tiles, vecs[i].exp_tiles);
         check_output("vec_busy_cycles", busy_cnt, vecs[i].exp_busy);
         check_output("vec_end_ofm", eo_cnt, (vecs[i].exp_tiles > 0) ? 1 : 0);
         check_output("vec_done", done_cnt, 1);
         check_output("vec_post_busy", post_busy, 0);
         check_output("vec_post_valid", post_valid, 0);
         if (vecs[i].exp_tiles > 0) begin
            check_output("vec_valid_first", 32'(tile_valid[0]), 32'(vecs[i].exp_v_first));
            check_output("vec_valid_last", 32'(tile_valid[vecs[i].exp_tiles-1]),
                         32'(vecs[i].exp_v_last));
         end
      end

      // Stall three cycles ahead of tap 8 of channel 0.
      apply_stimulus(4, 1, 2, 2, 8, 0, 0);
      check_output("stall_cycles", stall_cycles, 3);
      check_output("stall_tap_held", stall_at_tap, 3);
      check_output("stall_cc_after", cc_after_stall, 1);
      check_output("stall_en_count", en_cnt, 18);
      check_output("stall_cc_count", cc_cnt, 1);

      // Withhold tile_ack for 10 cycles after each tile_done.
      apply_stimulus(20, 1, 1, 11, -1, 0, 0);
      check_output("bp_tiles", tiles, 2);
      check_output("bp_drain_len0", drain_len[0], 11);
      check_output("bp_drain_len1", drain_len[1], 11);
      check_output("bp_drain_en", drain_en, 0);
      check_output("bp_frozen", frozen_err, 0);
      check_output("bp_next_tile_start", ack_start_err, 0);
      check_output("bp_en_count", en_cnt, 18);
      check_output("bp_busy_cycles", busy_cnt, 41);

      // start with new cfg while RUN must be ignored.
      apply_stimulus(20, 2, 2, 2, -1, 1, 0);
      check_output("restart_en_count", en_cnt, 72);
      check_output("restart_tiles", tiles, 4);
      check_output("restart_cr_count", cr_cnt, 1);

      // Reset during tile 2, then a fresh full pass.
      apply_stimulus(20, 2, 2, 2, -1, 0, 1);
      check_output("abort_end_ofm", eo_cnt, 0);
      check_output("abort_done", done_cnt, 0);
      check_output("abort_post_busy", post_busy, 0);
      check_output("abort_post_en", post_en, 0);
      apply_stimulus(20, 2, 2, 2, -1, 0, 0);
      check_output("fresh_en_count", en_cnt, 72);
      check_output("fresh_cc_count", cc_cnt, 4);
      check_output("fresh_tiles", tiles, 4);
      check_output("fresh_end_ofm", eo_cnt, 1);
      check_output("fresh_valid_tile1", 32'(tile_valid[1]), 32'h000F);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule

// File: doc/pe_tile_scheduler.md
Name: pe_tile_scheduler

Overview:
- Sequences the 16-PE convolution array and its address controllers over one output feature map (OFM).
- Walks the loop nest row, then column tile, then input channel, then kernel tap.
- Per cycle, drives the array enable, the per-PE valid mask and the row/channel/end-of-OFM strobes.
- After each tile, handshakes with the downstream accumulator/writeback buffer before starting the next tile.

Parameters:
- NUM_PE, 16, number of PEs; one tile = NUM_PE consecutive output pixels of one OFM row.
- KERNEL, 3, kernel side; taps per channel = KERNEL*KERNEL.
- CNT_W, 9, width of the row, column and channel counters and of the config inputs.
- TAP_W, $clog2(KERNEL*KERNEL), width of the tap counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a pass; sampled only in IDLE.
- cfg_ofm_w  in  CNT_W  OFM width in pixels.
- cfg_ofm_h  in  CNT_W  OFM height in rows.
- cfg_channels  in  CNT_W  number of input channels.
- stall  in  1  array/memory not ready; freezes RUN.
- tile_ack  in  1  downstream has consumed the finished tile.
- en  out  1  array/address-controller advance enable.
- valid  out  NUM_PE  per-PE valid mask for the current tile.
- change_channel  out  1  channel-advance strobe.
- change_row  out  1  row-advance strobe.
- end_ofm  out  1  last-tile-accepted strobe.
- tile_done  out  1  tile finished; waiting for tile_ack.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle completion pulse.
- cur_row  out  CNT_W  current OFM row.
- cur_col  out  CNT_W  column base of the current tile.
- cur_ch  out  CNT_W  current channel.
- cur_tap  out  TAP_W  current kernel tap.

Behaviour:
- Reset: all outputs 0, all counters 0, state IDLE. Reset asserted mid-pass aborts immediately, with no strobes; the next start is required after release.
- All outputs are registered.
- States: IDLE, RUN, DRAIN, FIN.
- IDLE:
  - start=1 latches the three cfg inputs and zeroes row/col/ch/tap.
  - If any latched cfg is 0: go to FIN with no en cycles.
  - Otherwise go to RUN; the first en appears in the cycle after start.
  - start in any other state is ignored.
- RUN, stall=0:
  - en=1.
  - tap increments each cycle.
  - At tap==KERNEL*KERNEL-1 with ch<channels-1: tap<=0, ch++, change_channel=1 in that same en cycle.
  - At tap==last with ch==channels-1: go to DRAIN.
- RUN, stall=1: en=0, all counters and strobes held/zero, state unchanged. A stall in the last-tap cycle delays that cycle's strobe until the cycle is actually enabled.
- valid:
  - Computed once when a tile is entered: n=min(NUM_PE, ofm_w-cur_col); valid[i]=1 for i<n.
  - Held constant for the whole tile, including DRAIN.
  - 0 in IDLE and FIN.
- DRAIN:
  - en=0 and tile_done=1, held until tile_ack=1.
  - On ack, if cur_col+NUM_PE < ofm_w: cur_col += NUM_PE, ch=tap=0, back to RUN.
  - On ack, otherwise, if cur_row < ofm_h-1: cur_row++, cur_col=0, ch=tap=0, change_row=1 for one cycle, back to RUN.
  - On ack, otherwise: end_ofm=1 for one cycle, go to FIN.
  - tile_ack outside DRAIN is ignored.
  - tile_ack held high causes one advance per DRAIN entry; the tile needs at least KERNEL*KERNEL en cycles before the next DRAIN.
- FIN: done=1 for one cycle, then IDLE. busy=1 in RUN, DRAIN and FIN.
- Arithmetic:
  - cur_col+NUM_PE is computed at CNT_W+1 bits so no wrap occurs at ofm_w near 2^CNT_W-1.
  - ofm_w-cur_col is always >0 in RUN.
- Counts per pass:
  - en cycles = ceil(w/NUM_PE)*h*channels*KERNEL^2.
  - change_channel pulses = tiles*(channels-1).
  - change_row pulses = h-1.
  - end_ofm pulses = 1.

Test Plan:
- Basic pass:
  - Stimulus: w=20, h=2, ch=2, no stall, ack one cycle after each tile_done.
  - Response: 4 tiles; valid 16'hFFFF, then 16'h000F, repeated per row; 18 en per tile (72 total); 4 change_channel; 1 change_row, after the 2nd ack; end_ofm after the 4th ack, then done; busy back to 0.
- Exact multiple:
  - Stimulus: w=16, h=1, ch=1.
  - Response: 9 en cycles; valid=16'hFFFF; no change_row; end_ofm on ack.
- Stall:
  - Stimulus: w=4, h=1, ch=2; stall high for 3 cycles at tap 8 of ch0.
  - Response: en=0 and cur_tap=8 held for 3 cycles; change_channel coincides with the first enabled cycle after the stall; 18 en total.
- Backpressure:
  - Stimulus: withhold tile_ack for 10 cycles.
  - Response: tile_done high and en=0 for all 10 cycles; counters frozen; next tile starts the cycle after ack.
- Zero config and ignored start:
  - Stimulus: start with cfg_channels=0.
  - Response: busy for 1 cycle (FIN), done=1, no en and no strobes.
  - Stimulus: start pulsed during RUN.
  - Response: no effect.
- Reset mid-pass:
  - Stimulus: assert reset_n=0 during RUN of tile 2.
  - Response: outputs 0 asynchronously; no end_ofm; a fresh start produces a full correct pass.
